// File: rtl/coin_pkg.sv
// Shared definitions for the coin credit controller: state encoding,
// coin-value decode and the product price table.
package coin_pkg;

  localparam int CREDIT_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_COLLECT  = 2'b01,
    ST_DISPENSE = 2'b10,
    ST_CHANGE   = 2'b11
  } state_t;

  // Coin code to units: 00=1, 01=2, 10=5, 11=10.
  function automatic logic [CREDIT_W-1:0] coin_units(input logic [1:0] code);
    logic [CREDIT_W-1:0] units;
    unique case (code)
      2'b00:   units = 5'd1;
      2'b01:   units = 5'd2;
      2'b10:   units = 5'd5;
      default: units = 5'd10;
    endcase
    return units;
  endfunction

  // Product index to price in units: 0=5, 1=7, 2=10, 3=12.
  function automatic logic [CREDIT_W-1:0] price(input logic [1:0] sel);
    logic [CREDIT_W-1:0] units;
    unique case (sel)
      2'b00:   units = 5'd5;
      2'b01:   units = 5'd7;
      2'b10:   units = 5'd10;
      default: units = 5'd12;
    endcase
    return units;
  endfunction

endpackage

// File: rtl/coin_adder.sv
// Combinational coin decode and add; flags sums that do not fit the
// 5-bit credit register so the caller can refuse the coin.
module coin_adder
  import coin_pkg::*;
(
  input  logic [CREDIT_W-1:0] credit,
  input  logic [1:0]          code,
  output logic [CREDIT_W-1:0] sum,
  output logic                overflow
);

  // One extra bit catches anything above 31.
  logic [CREDIT_W:0] wide_sum;

  assign wide_sum = {1'b0, credit} + {1'b0, coin_units(code)};
  assign sum      = wide_sum[CREDIT_W-1:0];
  assign overflow = wide_sum[CREDIT_W];

endmodule

// File: rtl/coin_credit.sv
// Vending credit controller: accumulates coins, sells products against a
// price table, hands the dispense off, then pays change one unit at a time.
module coin_credit
  import coin_pkg::*;
(
  input  logic                clk,
  input  logic                areset,
  input  logic                coin_valid,
  input  logic [1:0]          coin_val,
  input  logic                sel_valid,
  input  logic [1:0]          sel,
  input  logic                cancel,
  input  logic                disp_done,
  input  logic                chg_ack,
  output logic                disp_req,
  output logic [1:0]          disp_sel,
  output logic                chg_req,
  output logic [CREDIT_W-1:0] credit,
  output logic                coin_rej,
  output logic                low_funds,
  output logic [1:0]          state
);

  state_t              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic                disp_req_q, disp_req_d;
  logic [1:0]          disp_sel_q, disp_sel_d;
  logic                chg_req_q, chg_req_d;
  logic                coin_rej_q, coin_rej_d;
  logic                low_funds_q, low_funds_d;

  logic [CREDIT_W-1:0] coin_sum;
  logic                coin_ovf;
  logic                sel_ok;
  logic                accepting;

  coin_adder u_coin_adder (
    .credit   (credit_q),
    .code     (coin_val),
    .sum      (coin_sum),
    .overflow (coin_ovf)
  );

  assign sel_ok    = (credit_q >= price(sel));
  assign accepting = (state_q == ST_IDLE) || (state_q == ST_COLLECT);

  // State register.
  always_ff @(posedge clk or posedge areset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (areset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; cancel outranks coins, coins outrank selections.
  always_comb begin
    // NOTE: default first so no path through the case leaves state_d
    // unassigned, which would otherwise infer a latch.
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (coin_valid && !coin_ovf) state_d = ST_COLLECT;
      end
      ST_COLLECT: begin
        if (cancel)                       state_d = ST_CHANGE;
        else if (coin_valid)              state_d = ST_COLLECT;
        else if (sel_valid && sel_ok)     state_d = ST_DISPENSE;
      end
      ST_DISPENSE: begin
        if (disp_done) state_d = (credit_q != '0) ? ST_CHANGE : ST_IDLE;
      end
      ST_CHANGE: begin
        if (credit_q == '0 || (credit_q == 5'd1 && chg_req_q && chg_ack))
          state_d = ST_IDLE;
      end
    endcase
  end

  // Next values of credit and of every registered output.
  always_comb begin
    credit_d    = credit_q;
    disp_sel_d  = disp_sel_q;
    coin_rej_d  = 1'b0;
    low_funds_d = 1'b0;

    if (coin_valid) begin
      if (!accepting || coin_ovf || (state_q == ST_COLLECT && cancel))
        coin_rej_d = 1'b1;
      else
        credit_d = coin_sum;
    end

    if (sel_valid && !coin_valid) begin
      if (state_q == ST_IDLE) begin
        low_funds_d = 1'b1;
      end else if (state_q == ST_COLLECT && !cancel) begin
        if (sel_ok) begin
          credit_d   = credit_q - price(sel);
          disp_sel_d = sel;
        end else begin
          low_funds_d = 1'b1;
        end
      end
    end

    if (state_q == ST_CHANGE && chg_req_q && chg_ack && credit_q != '0)
      credit_d = credit_q - 5'd1;

    // Request lines follow the state being entered so they change on the
    // same edge as the state itself.
    disp_req_d = (state_d == ST_DISPENSE);
    chg_req_d  = (state_d == ST_CHANGE) && (credit_d != '0);
  end

  // Output and credit registers; reset discards any outstanding credit.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      credit_q    <= '0;
      disp_req_q  <= 1'b0;
      disp_sel_q  <= 2'b00;
      chg_req_q   <= 1'b0;
      coin_rej_q  <= 1'b0;
      low_funds_q <= 1'b0;
    end else begin
      credit_q    <= credit_d;
      disp_req_q  <= disp_req_d;
      disp_sel_q  <= disp_sel_d;
      chg_req_q   <= chg_req_d;
      coin_rej_q  <= coin_rej_d;
      low_funds_q <= low_funds_d;
    end
  end

  assign credit    = credit_q;
  assign disp_req  = disp_req_q;
  assign disp_sel  = disp_sel_q;
  assign chg_req   = chg_req_q;
  assign coin_rej  = coin_rej_q;
  assign low_funds = low_funds_q;
  assign state     = state_q;

endmodule

// File: tb/tb_coin_credit.sv
// Directed, table-driven bench for coin_credit.
module tb_coin_credit;

  logic       clk;
  logic       areset;
  logic       coin_valid;
  logic [1:0] coin_val;
  logic       sel_valid;
  logic [1:0] sel;
  logic       cancel;
  logic       disp_done;
  logic       chg_ack;
  logic       disp_req;
  logic [1:0] disp_sel;
  logic       chg_req;
  logic [4:0] credit;
  logic       coin_rej;
  logic       low_funds;
  logic [1:0] state;

  int checks   = 0;
  int failures = 0;

  coin_credit dut (
    .clk        (clk),
    .areset     (areset),
    .coin_valid (coin_valid),
    .coin_val   (coin_val),
    .sel_valid  (sel_valid),
    .sel        (sel),
    .cancel     (cancel),
    .disp_done  (disp_done),
    .chg_ack    (chg_ack),
    .disp_req   (disp_req),
    .disp_sel   (disp_sel),
    .chg_req    (chg_req),
    .credit     (credit),
    .coin_rej   (coin_rej),
    .low_funds  (low_funds),
    .state      (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock of stimulus and the outputs expected after that edge.
  typedef struct {
    logic       cv;
    logic [1:0] code;
    logic       sv;
    logic [1:0] sel;
    logic       can;
    logic       dd;
    logic       ack;
    logic [1:0] e_state;
    logic [4:0] e_credit;
    logic       e_dreq;
    logic [1:0] e_dsel;
    logic       e_creq;
    logic       e_rej;
    logic       e_low;
  } vec_t;

  function automatic vec_t mk(int cv, int code, int sv, int sl, int can, int dd,
                              int ack, int st, int cr, int dreq, int dsel,
                              int creq, int rej, int low);
    vec_t v;
    v.cv = 1'(cv);   v.code = 2'(code); v.sv = 1'(sv);     v.sel = 2'(sl);
    v.can = 1'(can); v.dd = 1'(dd);     v.ack = 1'(ack);
    v.e_state = 2'(st);  v.e_credit = 5'(cr); v.e_dreq = 1'(dreq);
    v.e_dsel = 2'(dsel); v.e_creq = 1'(creq); v.e_rej = 1'(rej);
    v.e_low = 1'(low);
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input vec_t v);
    check({tag, ".state"},     int'(state),     int'(v.e_state));
    check({tag, ".credit"},    int'(credit),    int'(v.e_credit));
    check({tag, ".disp_req"},  int'(disp_req),  int'(v.e_dreq));
    check({tag, ".disp_sel"},  int'(disp_sel),  int'(v.e_dsel));
    check({tag, ".chg_req"},   int'(chg_req),   int'(v.e_creq));
    check({tag, ".coin_rej"},  int'(coin_rej),  int'(v.e_rej));
    check({tag, ".low_funds"}, int'(low_funds), int'(v.e_low));
  endtask

  // Drive one vector, clock it in, and compare just after the edge.
  task automatic apply(input string tag, input vec_t v);
    coin_valid = v.cv;  coin_val  = v.code; sel_valid = v.sv;
    sel        = v.sel; cancel    = v.can;  disp_done = v.dd;
    chg_ack    = v.ack;
    @(posedge clk);
    #1;
    check_outputs(tag, v);
  endtask

  vec_t vecs[25];

  initial begin
    areset     = 1'b1;
    coin_valid = 1'b0; coin_val = 2'b00; sel_valid = 1'b0; sel = 2'b00;
    cancel     = 1'b0; disp_done = 1'b0; chg_ack = 1'b0;

    //          cv cd sv sl cn dd ak | st cr  dq ds cq rj lf
    // Coins 5,2 then product 1: exact change, no refund.
    vecs[0]  = mk(1, 2, 0, 0, 0, 0, 0,  1,  5, 0, 0, 0, 0, 0);
    vecs[1]  = mk(1, 1, 0, 0, 0, 0, 0,  1,  7, 0, 0, 0, 0, 0);
    vecs[2]  = mk(0, 0, 1, 1, 0, 0, 0,  2,  0, 1, 1, 0, 0, 0);
    vecs[3]  = mk(0, 0, 0, 0, 0, 0, 1,  2,  0, 1, 1, 0, 0, 0); // ack ignored
    vecs[4]  = mk(0, 0, 0, 0, 0, 1, 0,  0,  0, 0, 1, 0, 0, 0);
    vecs[5]  = mk(0, 0, 0, 0, 1, 1, 1,  0,  0, 0, 1, 0, 0, 0); // idle ignores
    vecs[6]  = mk(0, 0, 1, 0, 0, 0, 0,  0,  0, 0, 1, 0, 0, 1); // sel in idle
    // Coins 10,5 then product 2: five units of change.
    vecs[7]  = mk(1, 3, 0, 0, 0, 0, 0,  1, 10, 0, 1, 0, 0, 0);
    vecs[8]  = mk(1, 2, 0, 0, 0, 0, 0,  1, 15, 0, 1, 0, 0, 0);
    vecs[9]  = mk(0, 0, 1, 2, 0, 0, 0,  2,  5, 1, 2, 0, 0, 0);
    vecs[10] = mk(1, 0, 0, 0, 1, 0, 0,  2,  5, 1, 2, 0, 1, 0); // coin refused
    vecs[11] = mk(0, 0, 0, 0, 0, 1, 0,  3,  5, 0, 2, 1, 0, 0);
    vecs[12] = mk(0, 0, 0, 0, 0, 0, 0,  3,  5, 0, 2, 1, 0, 0);
    vecs[13] = mk(0, 0, 0, 0, 0, 0, 1,  3,  4, 0, 2, 1, 0, 0);
    vecs[14] = mk(1, 3, 0, 0, 0, 0, 1,  3,  3, 0, 2, 1, 1, 0);
    vecs[15] = mk(0, 0, 0, 0, 1, 1, 1,  3,  2, 0, 2, 1, 0, 0);
    vecs[16] = mk(0, 0, 0, 0, 0, 0, 1,  3,  1, 0, 2, 1, 0, 0);
    vecs[17] = mk(0, 0, 0, 0, 0, 0, 1,  0,  0, 0, 2, 0, 0, 0);
    vecs[18] = mk(0, 0, 0, 0, 0, 0, 1,  0,  0, 0, 2, 0, 0, 0);
    // Selection with a coin is dropped; then short funds; then build to 12.
    vecs[19] = mk(1, 2, 0, 0, 0, 0, 0,  1,  5, 0, 2, 0, 0, 0);
    vecs[20] = mk(1, 0, 1, 0, 0, 0, 0,  1,  6, 0, 2, 0, 0, 0);
    vecs[21] = mk(0, 0, 1, 1, 0, 0, 0,  1,  6, 0, 2, 0, 0, 1);
    vecs[22] = mk(1, 2, 0, 0, 0, 0, 0,  1, 11, 0, 2, 0, 0, 0);
    vecs[23] = mk(1, 0, 0, 0, 0, 0, 0,  1, 12, 0, 2, 0, 0, 0);
    // Cancel beats coin and selection together.
    vecs[24] = mk(1, 3, 1, 0, 1, 0, 0,  3, 12, 0, 2, 1, 1, 0);

    #12;
    check_outputs("reset", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    areset = 1'b0;

    for (int i = 0; i < 25; i++) apply($sformatf("v%0d", i), vecs[i]);

    // Refund all 12 units one acknowledge at a time.
    for (int i = 1; i <= 12; i++) begin
      int left;
      left = 12 - i;
      apply($sformatf("refund%0d", i),
            mk(0, 0, 0, 0, 0, 0, 1, (left != 0) ? 3 : 0, left, 0, 2,
               (left != 0) ? 1 : 0, 0, 0));
    end

    // Saturation edge: 30 + 2 refused, 30 + 1 fits, 31 + 1 refused.
    apply("sat0", mk(1, 3, 0, 0, 0, 0, 0, 1, 10, 0, 2, 0, 0, 0));
    apply("sat1", mk(1, 3, 0, 0, 0, 0, 0, 1, 20, 0, 2, 0, 0, 0));
    apply("sat2", mk(1, 3, 0, 0, 0, 0, 0, 1, 30, 0, 2, 0, 0, 0));
    apply("sat3", mk(1, 1, 0, 0, 0, 0, 0, 1, 30, 0, 2, 0, 1, 0));
    apply("sat4", mk(1, 0, 0, 0, 0, 0, 0, 1, 31, 0, 2, 0, 0, 0));
    apply("sat5", mk(1, 0, 0, 0, 0, 0, 0, 1, 31, 0, 2, 0, 1, 0));
    apply("sat6", mk(0, 0, 1, 3, 0, 0, 0, 2, 19, 1, 3, 0, 0, 0));
    apply("sat7", mk(0, 0, 0, 0, 0, 1, 0, 3, 19, 0, 3, 1, 0, 0));

    // Drain down to 4 units, then reset in the middle of the refund.
    for (int i = 1; i <= 15; i++)
      apply($sformatf("drain%0d", i),
            mk(0, 0, 0, 0, 0, 0, 1, 3, 19 - i, 0, 3, 1, 0, 0));

    #2 areset = 1'b1;
    #1;
    check("async_rst.state",   int'(state),   0);
    check("async_rst.credit",  int'(credit),  0);
    check("async_rst.chg_req", int'(chg_req), 0);
    check("async_rst.disp_sel", int'(disp_sel), 0);
    @(negedge clk);
    areset = 1'b0;
    apply("post_rst", mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
